// File: rtl/cpu_pkg.sv
// Shared definitions for the debug register-access port: opcodes, FSM states
// and default register-file geometry.
package cpu_pkg;

    localparam int unsigned NUM_REGS_DEFAULT = 8;
    localparam int unsigned ADDR_W_DEFAULT   = 3;
    localparam int unsigned DATA_W_DEFAULT   = 16;
    localparam int unsigned OP_W             = 2;

    typedef enum logic [OP_W-1:0] {
        DBG_OP_RSVD  = 2'b00,
        DBG_OP_READ  = 2'b01,
        DBG_OP_WRITE = 2'b10,
        DBG_OP_DUMP  = 2'b11
    } dbg_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } dbg_state_e;

endpackage

// File: rtl/reg_debug_port.sv
// Debug access controller: turns host READ/WRITE/DUMP commands into register-file
// accesses while the core is halted and returns one response per register touched.
module reg_debug_port
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W   = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_halted,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rsp_last,

    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dbg_state_e        state_q,     state_d;
    dbg_op_e           op_q,        op_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q,  rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              rsp_last_q,  rsp_last_d;
    logic [ADDR_W-1:0] rf_raddr_q,  rf_raddr_d;
    logic              rf_we_q,     rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q,  rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q,  rf_wdata_d;

    // Accept only from IDLE; halted is sampled live so a mid-command drop just blocks the next one.
    assign cmd_ready = (state_q == IDLE) && cpu_halted;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;
        rf_raddr_d  = rf_raddr_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cpu_halted) begin
                    op_d = dbg_op_e'(cmd_op);
                    case (dbg_op_e'(cmd_op))
                        DBG_OP_READ: begin
                            rf_raddr_d = cmd_addr;
                            state_d    = RD_ADDR;
                        end
                        DBG_OP_WRITE: begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = cmd_addr;
                            rf_wdata_d = cmd_data;
                            state_d    = WR;
                        end
                        DBG_OP_DUMP: begin
                            idx_d      = '0;
                            rf_raddr_d = '0;
                            state_d    = RD_ADDR;
                        end
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_addr_d  = cmd_addr;
                            rsp_data_d  = '0;
                            rsp_err_d   = 1'b1;
                            rsp_last_d  = 1'b1;
                            state_d     = RESP;
                        end
                    endcase
                end
            end
            RD_ADDR: begin
                rsp_valid_d = 1'b1;
                rsp_addr_d  = rf_raddr_q;
                rsp_data_d  = rf_read_data;
                rsp_err_d   = 1'b0;
                rsp_last_d  = (op_q != DBG_OP_DUMP) || (idx_q == LAST_IDX);
                state_d     = RESP;
            end
            WR: begin
                rsp_valid_d = 1'b1;
                rsp_addr_d  = rf_waddr_q;
                rsp_data_d  = rf_wdata_q;
                rsp_err_d   = 1'b0;
                rsp_last_d  = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // Response fields hold until the host takes them.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if ((op_q == DBG_OP_DUMP) && (idx_q < LAST_IDX)) begin
                        idx_d      = idx_q + ADDR_W'(1);
                        rf_raddr_d = idx_q + ADDR_W'(1);
                        state_d    = RD_ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= DBG_OP_RSVD;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            rf_raddr_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
            rf_raddr_q  <= rf_raddr_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_addr        = rsp_addr_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_err         = rsp_err_q;
    assign rsp_last        = rsp_last_q;
    assign rf_read_addr    = rf_raddr_q;
    assign rf_write_enable = rf_we_q;
    assign rf_write_addr   = rf_waddr_q;
    assign rf_write_data   = rf_wdata_q;

endmodule

// File: doc/reg_debug_port.md
Name: reg_debug_port

Overview:
- Debug access controller that initiates reads and writes on the CPU register-file ports; the register file is the responder.
- Accepts debug commands (read one register, write one register, dump all registers) over a valid/ready handshake while the CPU is halted.
- Returns one response per register accessed on a second valid/ready channel.
- Sits between the debug host link and the register file; its rf_* outputs are muxed onto the register-file ports by the core whenever the core is halted.

Parameters:
- NUM_REGS, 8, number of architectural registers.
- ADDR_W, 3, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- DATA_W, 16, register data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cpu_halted  input  1  core is halted; commands are accepted only while this is 1.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted on a cycle where cmd_valid and cmd_ready are both 1.
- cmd_op  input  2  00 reserved, 01 READ, 10 WRITE, 11 DUMP.
- cmd_addr  input  ADDR_W  target register for READ and WRITE; ignored for DUMP.
- cmd_data  input  DATA_W  write data for WRITE.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  host accepts the response.
- rsp_addr  output  ADDR_W  register the response refers to.
- rsp_data  output  DATA_W  read value, or the written value for WRITE.
- rsp_err  output  1  reserved opcode was received.
- rsp_last  output  1  final response of the command.
- rf_read_addr  output  ADDR_W  drives register-file read port A address.
- rf_read_data  input  DATA_W  register-file read data (combinational, same cycle as address).
- rf_write_enable  output  1  register-file write strobe.
- rf_write_addr  output  ADDR_W  register-file write address.
- rf_write_data  output  DATA_W  register-file write data.

Behaviour:
- Reset: all outputs 0, state IDLE, any dump counter 0.
- Reset asserted mid-operation aborts the operation immediately: no further writes, any pending response is dropped.
- cmd_ready = (state==IDLE) && cpu_halted, driven combinationally from registered state.
- Each state below is entered at the clock edge that ends the previous state.
- IDLE, on accept at edge N:
  - Latch op, addr and data.
  - READ -> RD_ADDR; WRITE -> WR; DUMP -> RD_ADDR with dump index 0; reserved -> RESP with rsp_err=1, rsp_data=0, rsp_addr=cmd_addr, rsp_last=1.
- RD_ADDR (one cycle):
  - rf_read_addr = latched addr (READ) or dump index (DUMP).
  - At the closing edge, capture rf_read_data into rsp_data and go to RESP.
  - READ response: rsp_valid first high in the cycle after edge N+1 (2-cycle latency).
- WR (exactly one cycle):
  - rf_write_enable=1 with the latched addr and data; the write commits at the closing edge (N+1).
  - Go to RESP with rsp_data = written data, rsp_last=1.
  - rf_write_enable is 0 in every other state and cycle.
- RESP:
  - rsp_valid=1; rsp_* hold stable until rsp_valid && rsp_ready.
  - On handshake, DUMP with index < NUM_REGS-1: increment index, go to RD_ADDR.
  - On handshake, any other case: go to IDLE.
- DUMP:
  - Produces NUM_REGS responses with rsp_addr 0..NUM_REGS-1 in order.
  - rsp_last=1 only on index NUM_REGS-1.
  - Back-to-back entries take 2 cycles each when rsp_ready is held high.
- Backpressure: rsp_ready=0 stalls RESP indefinitely with no data change.
- Response channel timing:
  - rsp_valid never drops without a handshake.
  - No combinational path from rsp_ready to rsp_valid.
- cpu_halted falling mid-command: the in-flight command (including a full DUMP) completes; no new command is accepted until it rises again.
- Read-after-write: a READ issued after a WRITE response returns the new value. No bypass is needed because the write commits before any new accept.
- Index arithmetic: the dump index is ADDR_W bits; compare against NUM_REGS-1; there is no wrap past the last register.

Decomposition:
- Shared package (cpu_pkg): DBG_OP_READ/WRITE/DUMP/RSVD opcode constants, the state enum {IDLE, RD_ADDR, WR, RESP}, NUM_REGS/ADDR_W/DATA_W defaults.
- Single flat module; no sub-module is warranted.

Test Plan:
- Reset then WRITE addr 3 data 0xBEEF with rsp_ready=1 -> rf_write_enable high for exactly one cycle with addr 3; response addr 3, data 0xBEEF, last=1, err=0; register file r3=0xBEEF.
- After the above, READ addr 3 -> rsp_valid rises 2 cycles after accept with data 0xBEEF, last=1.
- Preload r0..r7 = 0x1000+i, then DUMP with rsp_ready toggling randomly -> 8 responses, addr 0..7, data 0x1000..0x1007, last only on addr 7, data stable while stalled.
- cpu_halted=0 with cmd_valid=1 -> cmd_ready=0, no rf access. Raise cpu_halted -> command accepted.
- cmd_op=00 addr 5 -> single response err=1, addr 5, data 0, last=1; no write strobe.
- Assert reset_n=0 during a DUMP at index 4 -> rsp_valid=0 and rf_write_enable=0 immediately; after release state is IDLE and cmd_ready follows cpu_halted.
